// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the helper that tells multi-cycle shift ops apart from single-cycle ops.
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_XOR = 4'b1001,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shift; SRA copies the sign bit, SLL/SRL fill 0.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        data_out = data_in;
        case (op)
            OP_SLL:  data_out = {data_in[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  data_out = {1'b0, data_in[DATA_WIDTH-1:1]};
            OP_SRA:  data_out = {data_in[DATA_WIDTH-1], data_in[DATA_WIDTH-1:1]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish in one cycle, shifts iterate one bit
// position per cycle through a shared step unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    state_e                state, state_next;
    alu_op_e               op_in, op_q;
    logic [DATA_WIDTH-1:0] shift_q, step_out, comb_result;
    logic [SHAMT_W-1:0]    cnt_q, shamt;
    logic                  accept, shift_start;

    assign op_in       = alu_op_e'(Operation);
    assign shamt       = SrcB[SHAMT_W-1:0];
    assign busy        = (state == S_SHIFT);
    assign done        = (state == S_DONE);
    assign accept      = start && !busy;
    assign shift_start = is_shift(op_in) && (shamt != '0);

    alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .op       (op_q),
        .data_in  (shift_q),
        .data_out (step_out)
    );

    // A shift by zero leaves SrcA untouched and completes like any single-cycle op.
    always_comb begin
        comb_result = '0;
        case (op_in)
            OP_AND:  comb_result = SrcA & SrcB;
            OP_OR:   comb_result = SrcA | SrcB;
            OP_ADD:  comb_result = SrcA + SrcB;
            OP_SUB:  comb_result = SrcA - SrcB;
            OP_XOR:  comb_result = SrcA ^ SrcB;
            OP_EQ:   comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_SLT:  comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLL,
            OP_SRL,
            OP_SRA:  comb_result = SrcA;
            default: comb_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE,
            S_DONE: begin
                if (accept) state_next = shift_start ? S_SHIFT : S_DONE;
                else        state_next = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_q <= 1) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            op_q      <= OP_AND;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                if (shift_start) begin
                    shift_q <= SrcA;
                    cnt_q   <= shamt;
                    op_q    <= op_in;
                end else begin
                    ALUResult <= comb_result;
                    Zero      <= (comb_result == '0);
                end
            end else if (state == S_SHIFT) begin
                shift_q <= step_out;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    ALUResult <= step_out;
                    Zero      <= (step_out == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issued ops push expected result and done cycle,
// a negedge monitor checks done, results, hold behaviour and the busy window.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  Operation = 4'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy, done, Zero;
    logic [31:0] ALUResult;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          bfrom = 1;
    int          buntil = 0;
    logic        mon_en = 1'b0;
    logic        prev_reset = 1'b0;
    logic [31:0] held = '0;
    logic        held_zero = 1'b1;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .busy      (busy),
        .done      (done),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation table, shifts done in one go.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a << n;
            4'b0101: return a >> n;
            4'b0111: return $signed(a) >>> n;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return a ^ b;
            4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called aligned at posedge+1; returns aligned one cycle after the accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int   g;
        int   n;
        logic sh;
        exp_t x;
        g = 0;
        while (busy === 1'b1 && g < 100) begin
            step(1);
            g++;
        end
        check("issue_wait_busy", {31'b0, busy}, 32'd0);
        start     = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        n  = int'(b[4:0]);
        sh = is_shift_op(op) && (n != 0);
        x.res = model(op, a, b);
        x.cyc = cyc + (sh ? n + 1 : 1);
        q.push_back(x);
        if (sh) begin
            bfrom  = cyc + 1;
            buntil = cyc + n;
        end
        step(1);
        start     = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    // Raise start without expecting any response (used while busy).
    task automatic poke(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        step(1);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_reset) begin
                held      = '0;
                held_zero = 1'b1;
            end
            check("busy_window", {31'b0, busy},
                  {31'b0, (cyc >= bfrom && cyc <= buntil) && !prev_reset});
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("result", ALUResult, e.res);
                    check("zero", {31'b0, Zero}, {31'b0, (e.res == 32'd0)});
                    check("done_cycle", cyc, e.cyc);
                    held      = e.res;
                    held_zero = (e.res == 32'd0);
                end
            end else begin
                check("result_hold", ALUResult, held);
                check("zero_hold", {31'b0, Zero}, {31'b0, held_zero});
            end
        end
        prev_reset = reset;
    end

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1100};

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          g;

        step(3);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", {31'b0, Zero}, 32'd1);
        reset = 1'b0;
        step(1);
        mon_en = 1'b1;

        issue(4'b0010, 32'd5, 32'd7);
        issue(4'b0011, 32'd3, 32'd5);
        issue(4'b1000, 32'h1234, 32'h1234);
        issue(4'b0011, 32'd9, 32'd9);
        step(1);
        issue(4'b0111, 32'h8000_0000, 32'd4);
        issue(4'b0101, 32'h8000_0000, 32'd4);
        issue(4'b0100, 32'h1, 32'd0);
        issue(4'b0100, 32'h1, 32'd31);
        step(2);

        // Shift by 8, an ADD raised mid-shift is dropped, a second ADD lands in DONE.
        issue(4'b0100, 32'h0000_00A5, 32'd8);
        step(1);
        poke(4'b0010, 32'd1, 32'd2);
        issue(4'b0010, 32'd100, 32'd23);
        step(2);

        // Reset two cycles into an SRA by 10 aborts it.
        start     = 1'b1;
        Operation = 4'b0111;
        SrcA      = 32'hC000_0001;
        SrcB      = 32'd10;
        bfrom     = cyc + 1;
        buntil    = cyc + 2;
        step(1);
        start = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", ALUResult, 32'd0);
        check("abort_zero", {31'b0, Zero}, 32'd1);
        step(12);

        issue(4'b1100, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'b1100, 32'd1, 32'hFFFF_FFFF);

        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if (is_shift_op(op)) begin
                b[4:0] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
                if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            end
            issue(op, a, b);
            if (busy === 1'b1 && $urandom_range(0, 1) == 1)
                poke(ops[$urandom_range(0, 9)], $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
        end

        g = 0;
        while (q.size() > 0 && g < 100) begin
            step(1);
            g++;
        end
        check("queue_drain", q.size(), 32'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 DATA_WIDTH, 32, operand/result width; shift amount width SHAMT_W = $clog2(DATA_WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation.
REQ-005 Operation  input  4  ALU operation code from ALUController.
REQ-006 SrcA  input  DATA_WIDTH  operand A.
REQ-007 SrcB  input  DATA_WIDTH  operand B; bits [SHAMT_W-1:0] are the shift amount for shift ops.
REQ-008 busy  output  1  high while a shift is iterating; start is ignored while high.
REQ-009 done  output  1  one-cycle pulse; ALUResult/Zero valid and updated in this cycle.
REQ-010 ALUResult  output  DATA_WIDTH  registered result, held until the next done.
REQ-011 Zero  output  1  registered (ALUResult == 0), updated with ALUResult.

Function
REQ-012 Operation encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0111 SRA, 1000 EQ, 1001 XOR, 1100 SLT (signed); all other codes yield result 0.
REQ-013 Arithmetic modulo 2^DATA_WIDTH, carry/overflow discarded; SLT and EQ yield 1 or 0 zero-extended.
REQ-014 FSM states: IDLE, SHIFT, DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-015 Accept = start && !busy, legal in IDLE or DONE (back-to-back issue allowed); operands and Operation sampled only at accept.
REQ-016 Non-shift op, or shift with shamt 0, accepted at cycle T: next state DONE, result/done at T+1.
REQ-017 Shift op with shamt N>0 accepted at cycle T: shift register loads SrcA and counter loads N; SHIFT occupies cycles T+1..T+N, one bit position per cycle; DONE at T+N+1.
REQ-018 SRA replicates the MSB on every step; SRL and SLL fill with 0.
REQ-019 SHIFT -> DONE when the counter equals 1 at the step; counter never wraps below 0.
REQ-020 DONE without accept -> IDLE; DONE with accept -> DONE (non-shift) or SHIFT (shift, N>0).
REQ-021 start during SHIFT is ignored, not queued; the in-flight op completes unchanged.
REQ-022 Operand changes after accept do not affect the in-flight result.
REQ-023 ALUResult and Zero change only on the edge entering DONE.

Reset
REQ-024 reset forces IDLE, busy=0, done=0, ALUResult=0, Zero=1, counter=0, shift register=0.
REQ-025 reset mid-SHIFT aborts the op with no done pulse; reset has priority over start in the same cycle.

Structure
REQ-026 Shared package alu_pkg holds the Operation code constants (as an enum of width 4) and the FSM state enum.
REQ-027 One sub-module alu_shift_step: combinational one-position shift (SLL/SRL/SRA select), instantiated once in the SHIFT datapath.
REQ-028 Single-cycle ops computed combinationally from sampled inputs at accept and registered into ALUResult.

Verification
REQ-029 ADD 5+7 accepted at T -> done=1 and ALUResult=12, Zero=0 at T+1; busy never high.
REQ-030 SUB 3-5 -> ALUResult=0xFFFFFFFE at T+1; EQ 0x1234 vs 0x1234 -> ALUResult=1; SUB 9-9 -> Zero=1.
REQ-031 SRA 0x80000000 by 4 at T -> busy high T+1..T+4, done at T+5, ALUResult=0xF8000000; SRL same operands -> 0x08000000.
REQ-032 SLL 0x1 by 0 -> done at T+1, ALUResult=0x1; SLL 0x1 by 31 -> done at T+32, ALUResult=0x80000000.
REQ-033 SLL by 8 at T, start ADD at T+3 -> ADD ignored; only one done at T+9 with the shift result; ADD issued in the DONE cycle completes 1 cycle later.
REQ-034 Reset at T+2 of an SRA by 10 -> IDLE next cycle, no done, ALUResult=0, Zero=1; SLT -1 vs 1 -> 1, undefined code 1111 -> 0.
